// File: rtl/dm_bridge_pkg.sv
// Shared types and constants for the CPU data-memory to bus bridge.
package dm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dm_br_state_e;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

  localparam logic [BUS_DATA_W-1:0] DM_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [BUS_BE_W-1:0]   BE_FULL     = 4'hF;

  // One bus command as seen on the bus side of the bridge (default widths)
  typedef struct packed {
    logic                  we;
    logic [BUS_BE_W-1:0]   be;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } dm_bus_txn_t;

endpackage

// File: rtl/dm_bus_bridge_if.sv
// CPU data-memory port plus handshaked data-bus signals seen by the bridge.
interface dm_bus_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              cpu_rd_en;
  logic [BE_W-1:0]   cpu_wr_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              bus_req;
  logic              bus_we;
  logic [BE_W-1:0]   bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  // Bridge side
  modport master (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    output cpu_rdata, cpu_stall, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err
  );

  // CPU plus bus-target side
  modport slave (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    input  cpu_rdata, cpu_stall, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/dm_bridge_wdog.sv
// REQ-phase wait counter; flags expiry on the TIMEOUT_CYC-th REQ cycle.
// Only compiled when DM_BRIDGE_TIMEOUT_EN is defined.
`ifdef DM_BRIDGE_TIMEOUT_EN
module dm_bridge_wdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired_c
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter restarts from zero every time the bridge re-enters REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!active) begin
      cnt_q <= '0;
    end else if (!expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = active && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
endmodule
`endif

// File: rtl/dm_bus_bridge.sv
// Bridges the single-cycle CPU dm request onto a held bus_req/bus_ack transaction.
// Defining DM_BRIDGE_TIMEOUT_EN adds a REQ watchdog that aborts and raises bus_err.
module dm_bus_bridge
  import dm_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic            clk,
  input logic            rst,
  dm_bus_bridge_if.master br
);
  localparam int unsigned BE_W = DATA_W / 8;

  dm_br_state_e      state_q, state_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              wr_req_c, cpu_req_c, stall_c, in_req_c, tmo_c;

  if (TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("dm_bus_bridge: TIMEOUT_CYC must be nonzero");
  end

  assign wr_req_c  = |br.cpu_wr_en;
  assign cpu_req_c = br.cpu_rd_en | wr_req_c;
  assign in_req_c  = (state_q == REQ);

`ifdef DM_BRIDGE_TIMEOUT_EN
  dm_bridge_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .active    (in_req_c),
    .expired_c (tmo_c)
  );
`else
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state, command capture and read-data update
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_c) begin
          stall_c = 1'b1;
          state_d = REQ;
          we_d    = wr_req_c;
          be_d    = wr_req_c ? br.cpu_wr_en : {BE_W{1'b1}};
          addr_d  = br.cpu_addr;
          wdata_d = br.cpu_wdata;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (br.bus_ack) begin
          if (!we_q) rdata_d = br.bus_rdata;
          state_d = DONE;
        end else if (tmo_c) begin
          if (!we_q) rdata_d = DATA_W'(DM_ERR_DATA);
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      // One unstalled cycle lets the CPU retire the access; its stale request is ignored
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign br.cpu_stall = stall_c & rst;
  assign br.cpu_rdata = rdata_q;
  assign br.bus_req   = in_req_c;
  assign br.bus_we    = we_q;
  assign br.bus_be    = be_q;
  assign br.bus_addr  = addr_q;
  assign br.bus_wdata = wdata_q;
  assign br.bus_err   = err_q;
endmodule

// File: tb/tb_dm_bus_bridge.sv
// Scoreboard bench for dm_bus_bridge; the watchdog scenario runs when DM_BRIDGE_TIMEOUT_EN is defined.
module tb_dm_bus_bridge;
  import dm_bridge_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk;
  logic rst;

  dm_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  dm_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bif)
  );

  int          total;
  int          bad;
  int          n_txn;
  dm_bus_txn_t exp_q[$];
  int unsigned ack_wait;
  int unsigned wait_cnt;
  logic [31:0] rd_val;
  logic [31:0] exp_rdata;
  logic        spur_ack;
  logic        s_stall;
  logic        s_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: sample outputs, act as bus target, score the bus command, wait for next negedge
  task automatic cycle();
    logic        ack_now;
    dm_bus_txn_t obs;
    #1;
    s_stall = bif.cpu_stall;
    s_req   = bif.bus_req;
    ack_now = 1'b0;
    if (s_req) begin
      if (wait_cnt >= ack_wait) ack_now = 1'b1;
      else wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    bif.bus_ack   = ack_now | spur_ack;
    bif.bus_rdata = ack_now ? rd_val : (spur_ack ? 32'hFFFF_FFFF : 32'hA5A5_A5A5);
    if (s_req) begin
      obs.we = bif.bus_we; obs.be = bif.bus_be; obs.addr = bif.bus_addr; obs.wdata = bif.bus_wdata;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL bus_cmd: unexpected request we=%b be=%b addr=%h wdata=%h",
                 obs.we, obs.be, obs.addr, obs.wdata);
      end else if (obs !== exp_q[0]) begin
        bad++;
        $display("FAIL bus_cmd: got we=%b be=%b addr=%h wdata=%h want we=%b be=%b addr=%h wdata=%h",
                 obs.we, obs.be, obs.addr, obs.wdata,
                 exp_q[0].we, exp_q[0].be, exp_q[0].addr, exp_q[0].wdata);
      end
      if (ack_now && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_txn++;
      end
    end
    @(negedge clk);
  endtask

  // Present one CPU access and clock until the CPU is released (stall low)
  task automatic do_access(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned aw, input logic [31:0] rv,
                           output int stalls, output int reqs);
    dm_bus_txn_t e;
    bit          done;
    bif.cpu_rd_en = rd; bif.cpu_wr_en = wr; bif.cpu_addr = addr; bif.cpu_wdata = wdata;
    ack_wait = aw; rd_val = rv;
    e.we = |wr; e.be = (|wr) ? wr : BE_FULL; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
    stalls = 0; reqs = 0; done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (s_req) reqs++;
      if (s_stall) stalls++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_wait: stall still high after 64 cycles addr=%h", addr);
    end
  endtask

  task automatic idle(input int n);
    bif.cpu_rd_en = 1'b0; bif.cpu_wr_en = '0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
    for (int i = 0; i < n; i++) begin
      cycle();
      total++;
      if (s_req !== 1'b0 || s_stall !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet: got req=%b stall=%b want 0 0", s_req, s_stall);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; spur_ack = 1'b0; ack_wait = 0; wait_cnt = 0; rd_val = '0;
    bif.cpu_rd_en = 1'b0; bif.cpu_wr_en = '0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    exp_rdata = '0;
    @(negedge clk); @(negedge clk); #1;
    total++; if (bif.bus_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bif.bus_req); end
    total++; if (bif.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bif.cpu_stall); end
    total++; if (bif.cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bif.cpu_rdata); end
    total++; if (bif.bus_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bif.bus_err); end
    total++;
    if ({bif.bus_we, bif.bus_be, bif.bus_addr, bif.bus_wdata} !== 69'h0) begin
      bad++;
      $display("FAIL rst_cmd: got we=%b be=%b addr=%h wdata=%h want all 0",
               bif.bus_we, bif.bus_be, bif.bus_addr, bif.bus_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_imm();
    int st, rq, n0;
    n0 = n_txn;
    do_access(1'b1, 4'b0000, 32'h100, 32'h0, 0, 32'h1234_5678, st, rq);
    exp_rdata = 32'h1234_5678;
    total++; if (st != 2) begin bad++; $display("FAIL rd_stall_cycles: got %0d want 2", st); end
    total++; if (rq != 1) begin bad++; $display("FAIL rd_req_cycles: got %0d want 1", rq); end
    total++; if (n_txn - n0 != 1) begin bad++; $display("FAIL rd_txn_count: got %0d want 1", n_txn - n0); end
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL rd_data: got %h want %h", bif.cpu_rdata, exp_rdata); end
    idle(2);
  endtask

  task automatic test_write_waits();
    int st, rq;
    do_access(1'b0, 4'b0100, 32'h203, 32'h00AB_0000, 4, 32'h0BAD_0BAD, st, rq);
    total++; if (st != 6) begin bad++; $display("FAIL wr_stall_cycles: got %0d want 6", st); end
    total++; if (rq != 5) begin bad++; $display("FAIL wr_req_cycles: got %0d want 5", rq); end
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL wr_rdata_kept: got %h want %h", bif.cpu_rdata, exp_rdata); end
    idle(2);
  endtask

  // Read immediately followed by a write (rd_en also high: write must win)
  task automatic test_back_to_back();
    int st1, rq1, st2, rq2, n0;
    n0 = n_txn;
    do_access(1'b1, 4'b0000, 32'h40, 32'hFFFF_0000, 1, 32'hCAFE_F00D, st1, rq1);
    do_access(1'b1, 4'b1111, 32'h44, 32'h1122_3344, 0, 32'h0BAD_0BAD, st2, rq2);
    exp_rdata = 32'hCAFE_F00D;
    idle(4);
    total++; if (n_txn - n0 != 2) begin bad++; $display("FAIL b2b_txn_count: got %0d want 2", n_txn - n0); end
    total++; if (st1 != 3 || rq1 != 2) begin bad++; $display("FAIL b2b_rd_timing: got stall=%0d req=%0d want 3 2", st1, rq1); end
    total++; if (st2 != 2 || rq2 != 1) begin bad++; $display("FAIL b2b_wr_timing: got stall=%0d req=%0d want 2 1", st2, rq2); end
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL b2b_rdata: got %h want %h", bif.cpu_rdata, exp_rdata); end
  endtask

  task automatic test_spurious_ack();
    int st, rq;
    spur_ack = 1'b1;
    idle(3);
    spur_ack = 1'b0;
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL spur_rdata: got %h want %h", bif.cpu_rdata, exp_rdata); end
    do_access(1'b1, 4'b0000, 32'h80, 32'h0, 0, 32'h55AA_55AA, st, rq);
    exp_rdata = 32'h55AA_55AA;
    total++; if (st != 2 || rq != 1) begin bad++; $display("FAIL spur_next_timing: got stall=%0d req=%0d want 2 1", st, rq); end
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL spur_next_rdata: got %h want %h", bif.cpu_rdata, exp_rdata); end
    idle(2);
  endtask

  task automatic test_reset_mid_req();
    dm_bus_txn_t e;
    bif.cpu_rd_en = 1'b1; bif.cpu_wr_en = '0; bif.cpu_addr = 32'h300; bif.cpu_wdata = '0;
    ack_wait = 1000;
    e.we = 1'b0; e.be = BE_FULL; e.addr = 32'h300; e.wdata = '0;
    exp_q.push_back(e);
    cycle(); cycle(); cycle();
    total++; if (s_req !== 1'b1) begin bad++; $display("FAIL mid_pre_req: got %b want 1", s_req); end
    rst = 1'b0;
    #1;
    total++; if (bif.bus_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req: got %b want 0", bif.bus_req); end
    total++; if (bif.cpu_stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall: got %b want 0", bif.cpu_stall); end
    total++; if (bif.cpu_rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata: got %h want 0", bif.cpu_rdata); end
    exp_q.delete();
    exp_rdata = '0;
    bif.cpu_rd_en = 1'b0; ack_wait = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(3);
  endtask

`ifdef DM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int st, rq, n0;
    n0 = n_txn;
    do_access(1'b1, 4'b0000, 32'h500, 32'h0, 1000, 32'h0, st, rq);
    exp_q.delete();
    exp_rdata = DM_ERR_DATA;
    total++; if (st != 9 || rq != int'(TMO)) begin bad++; $display("FAIL tmo_timing: got stall=%0d req=%0d want 9 8", st, rq); end
    total++; if (bif.bus_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", bif.bus_err); end
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL tmo_rdata: got %h want %h", bif.cpu_rdata, exp_rdata); end
    total++; if (n_txn != n0) begin bad++; $display("FAIL tmo_txn_count: got %0d want %0d", n_txn, n0); end
    idle(2);
    do_access(1'b0, 4'b0011, 32'h600, 32'h0000_BEEF, 0, 32'h0BAD_0BAD, st, rq);
    idle(1);
    total++; if (st != 2) begin bad++; $display("FAIL tmo_after_wr: got stall=%0d want 2", st); end
    total++; if (bif.bus_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky: got %b want 1", bif.bus_err); end
    total++; if (bif.cpu_rdata !== exp_rdata) begin bad++; $display("FAIL tmo_rdata_kept: got %h want %h", bif.cpu_rdata, exp_rdata); end
  endtask
`endif

  initial begin
    total = 0; bad = 0; n_txn = 0;
    s_stall = 1'b0; s_req = 1'b0;
    test_reset();
    test_read_imm();
    test_write_waits();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_req();
`ifdef DM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
